// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, loader request classes, loader states and
// the field-level request payload consumed by the encoder.
package rv32i_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 13;
  localparam int unsigned CLS_W = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [CLS_W-1:0] CLS_LOAD   = 3'd0;
  localparam logic [CLS_W-1:0] CLS_STORE  = 3'd1;
  localparam logic [CLS_W-1:0] CLS_RTYPE  = 3'd2;
  localparam logic [CLS_W-1:0] CLS_BRANCH = 3'd3;
  localparam logic [CLS_W-1:0] CLS_ITYPE  = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } load_state_e;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [2:0]       funct3;
    logic             f7b5;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instr_req_t;

endpackage

// File: rtl/rv32i_field_encoder.sv
// Combinational field-to-word encoder for the five decoder-recognised classes;
// flags unknown classes and misaligned branch offsets as illegal.
module rv32i_field_encoder
  import rv32i_pkg::*;
(
  input  instr_req_t        req,
  output logic [XLEN-1:0]   word,
  output logic              illegal
);

  logic shift_op;

  // Shift immediates carry the funct7 pattern in place of imm[11:5].
  assign shift_op = (req.funct3 == 3'b001) || (req.funct3 == 3'b101);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.cls)
      CLS_LOAD:
        word = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD};
      CLS_STORE:
        word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], OP_STORE};
      CLS_RTYPE:
        word = {1'b0, req.f7b5, 5'b00000, req.rs2, req.rs1, req.funct3, req.rd, OP_RTYPE};
      CLS_BRANCH: begin
        word    = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                   req.imm[4:1], req.imm[11], OP_BRANCH};
        illegal = req.imm[0];
      end
      CLS_ITYPE: begin
        if (shift_op)
          word = {1'b0, req.f7b5, 5'b00000, req.imm[4:0], req.rs1, req.funct3, req.rd, OP_ITYPE};
        else
          word = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_ITYPE};
      end
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction requests and writes them sequentially into
// instruction memory, one word per two cycles, until DEPTH words are written.
module instr_encoder_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CLS_W-1:0]  in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  load_state_e      state;
  instr_req_t       req;
  logic [XLEN-1:0]  enc_word;
  logic             enc_illegal;
  logic [CNT_W-1:0] count_inc;
  logic             at_depth;

  assign req = '{cls: in_class, funct3: in_funct3, f7b5: in_funct7b5,
                 rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  rv32i_field_encoder u_enc (
    .req     (req),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign count_inc = count + CNT_W'(1);
  assign at_depth  = (count_inc == CNT_W'(DEPTH));

  // Loader FSM; in_ready is registered so it is low throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      err     <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        in_ready  <= 1'b1;
        imem_addr <= ADDR_W'(BASE_ADDR);
        count     <= '0;
        full      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            in_ready <= !full;
            if (in_valid && in_ready) begin
              if (enc_illegal) begin
                err <= 1'b1;
              end else begin
                imem_wdata <= enc_word;
                imem_we    <= 1'b1;
                in_ready   <= 1'b0;
                state      <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            state     <= ST_IDLE;
            imem_addr <= imem_addr + ADDR_W'(1);
            count     <= count_inc;
            full      <= at_depth;
            in_ready  <= !at_depth;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with DEPTH = 4 and hand-assembled
// expected RV32I words.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm);
    in_class = c; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Issue one request, capture the WRITE-cycle outputs, then return to IDLE.
  task automatic do_write(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [12:0] imm, output logic we_o,
                          output logic [7:0] a_o, output logic [31:0] d_o);
    int n = 0;
    set_req(c, f3, f7, rd, rs1, rs2, imm);
    while (!in_ready && n < 20) begin tick(); n++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait got %b exp 1", in_ready);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    we_o = imem_we; a_o = imem_addr; d_o = imem_wdata;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", imem_we); end
    n_cmp++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr got %h exp 00", imem_addr); end
    n_cmp++; if (count !== 9'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (full !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_full_err got %b%b exp 00", full, err); end
    n_cmp++; if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", imem_wdata); end
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    logic we; logic [7:0] a; logic [31:0] d;
    do_write(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, we, a, d);
    n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL addi_we got %b exp 1", we); end
    n_cmp++; if (a !== 8'd0) begin n_fail++; $display("FAIL addi_addr got %h exp 00", a); end
    n_cmp++; if (d !== 32'h00500093) begin n_fail++; $display("FAIL addi_word got %h exp 00500093", d); end
    n_cmp++; if (count !== 9'd1) begin n_fail++; $display("FAIL addi_count got %0d exp 1", count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy;
    set_req(3'd0, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 13'd8);
    rdy[0] = in_ready;
    in_valid = 1'b1;
    tick();
    rdy[1] = in_ready;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h0080A103) begin
      n_fail++; $display("FAIL lw_write got we=%b a=%h d=%h exp we=1 a=01 d=0080a103", imem_we, imem_addr, imem_wdata);
    end
    set_req(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 13'd12);
    tick();
    rdy[2] = in_ready;
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_we got %b exp 0", imem_we); end
    tick();
    rdy[3] = in_ready;
    in_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'd2 || imem_wdata !== 32'h0020A623) begin
      n_fail++; $display("FAIL sw_write got we=%b a=%h d=%h exp we=1 a=02 d=0020a623", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++; if (rdy !== 4'b0101) begin n_fail++; $display("FAIL ready_toggle got %b exp 0101 (bit0 first)", rdy); end
    tick();
    n_cmp++; if (count !== 9'd3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", count); end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_req(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd4);
      else        set_req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'd3);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (err !== 1'b1 || imem_we !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_pulse got err=%b we=%b exp err=1 we=0", k, err, imem_we);
      end
      tick();
      n_cmp++; if (err !== 1'b0 || imem_we !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_after got err=%b we=%b exp err=0 we=0", k, err, imem_we);
      end
      n_cmp++; if (imem_addr !== 8'd3 || count !== 9'd3) begin
        n_fail++; $display("FAIL illegal%0d_state got a=%h c=%0d exp a=03 c=3", k, imem_addr, count);
      end
    end
  endtask

  task automatic test_full_and_clear();
    logic we; logic [7:0] a; logic [31:0] d;
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (count !== 9'd0 || imem_addr !== 8'd0 || full !== 1'b0) begin
      n_fail++; $display("FAIL clear1 got c=%0d a=%h f=%b exp c=0 a=00 f=0", count, imem_addr, full);
    end
    do_write(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 8'd0 || d !== 32'h402081B3) begin
      n_fail++; $display("FAIL sub got we=%b a=%h d=%h exp we=1 a=00 d=402081b3", we, a, d);
    end
    do_write(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 8'd1 || d !== 32'hFE208EE3) begin
      n_fail++; $display("FAIL beq got we=%b a=%h d=%h exp we=1 a=01 d=fe208ee3", we, a, d);
    end
    do_write(3'd4, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 13'h0FE3, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 8'd2 || d !== 32'h40335293) begin
      n_fail++; $display("FAIL srai got we=%b a=%h d=%h exp we=1 a=02 d=40335293", we, a, d);
    end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL early_full got %b exp 0", full); end
    do_write(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 8'd3) begin n_fail++; $display("FAIL fourth got we=%b a=%h exp we=1 a=03", we, a); end
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 9'd4) begin
      n_fail++; $display("FAIL full_state got f=%b r=%b c=%0d exp f=1 r=0 c=4", full, in_ready, count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_we !== 1'b0 || count !== 9'd4) begin
        n_fail++; $display("FAIL fifth_blocked%0d got we=%b c=%0d exp we=0 c=4", i, imem_we, count);
      end
    end
    in_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (full !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear2 got f=%b r=%b exp f=0 r=1", full, in_ready);
    end
    do_write(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 8'd0 || d !== 32'h00500093) begin
      n_fail++; $display("FAIL after_clear got we=%b a=%h d=%h exp we=1 a=00 d=00500093", we, a, d);
    end
  endtask

  task automatic test_reset_mid_write();
    set_req(3'd0, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 13'd8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'd1) begin
      n_fail++; $display("FAIL midw_setup got we=%b a=%h exp we=1 a=01", imem_we, imem_addr);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL async_we_drop got %b exp 0", imem_we); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got %b exp 0", in_ready); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (imem_addr !== 8'd0 || count !== 9'd0 || imem_we !== 1'b0) begin
      n_fail++; $display("FAIL post_midw got a=%h c=%0d we=%b exp a=00 c=0 we=0", imem_addr, count, imem_we);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_full_and_clear();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
